// File: rtl/scalar_alu_arbiter.sv
// scalar_alu_arbiter
// Shares one combinational scalar ALU between NREQ requesters using round-robin
// arbitration. The granted request's operands and opcode are registered and drive
// the ALU for one cycle. The result and flags are then captured into a response
// register, which holds until the requester consumes it.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     per-requester handshake; ready is a one-hot accept pulse
//   req_a/req_b/req_op  packed request fields, requester i at [i*N +: N] / [i*3 +: 3]
//   alu_A/alu_B/alu_ctrl registered ALU inputs
//   alu_out/alu_flags   ALU result and {c,z,gt,v,n}
//   rsp_valid           one-hot response owner
//   rsp_data/rsp_flags  captured result and flags
//   rsp_ready           response consumed
//   busy                high whenever the FSM is not IDLE
//   rsp_err             (ALU_OP_CHECK_EN only) response carries an unsupported-op error
//
// Optional feature macro: ALU_OP_CHECK_EN
//   If defined, opcodes with bit2 set are accepted but never reach the ALU. The
//   response returns zero data and flags with rsp_err set.
//
// state | meaning
// IDLE  | waiting for any req_valid; grant is combinational
// EXEC  | registered operands drive the ALU; result captured at end of cycle
// RESP  | response held until rsp_ready
module scalar_alu_arbiter #(
   parameter int N    = 24,
   parameter int NREQ = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*N-1:0] req_a,
   input  logic [NREQ*N-1:0] req_b,
   input  logic [NREQ*3-1:0] req_op,
   output logic [N-1:0]      alu_A,
   output logic [N-1:0]      alu_B,
   output logic [2:0]        alu_ctrl,
   input  logic [N-1:0]      alu_out,
   input  logic [4:0]        alu_flags,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [N-1:0]      rsp_data,
   output logic [4:0]        rsp_flags,
   input  logic              rsp_ready,
   output logic              busy
`ifdef ALU_OP_CHECK_EN
   ,
   output logic              rsp_err
`endif
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]  grant_q, grant_d;
   logic [N-1:0]      alu_a_q, alu_a_d;
   logic [N-1:0]      alu_b_q, alu_b_d;
   logic [2:0]        alu_ctrl_q, alu_ctrl_d;
   logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [N-1:0]      rsp_data_q, rsp_data_d;
   logic [4:0]        rsp_flags_q, rsp_flags_d;
`ifdef ALU_OP_CHECK_EN
   logic              op_err_q, op_err_d;
   logic              rsp_err_q, rsp_err_d;
`endif

   logic              any_req;
   logic [PTR_W-1:0]  grant_idx;
   logic [PTR_W-1:0]  scan_sel;
   int                scan_idx;
   logic [N-1:0]      sel_a;
   logic [N-1:0]      sel_b;
   logic [2:0]        sel_op;

   // Round-robin scan from rr_ptr. The loop runs from farthest to nearest so the
   // last hit, which is the closest to rr_ptr, wins.
   always_comb begin
      any_req   = 1'b0;
      grant_idx = '0;
      scan_idx  = 0;
      scan_sel  = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         scan_idx = int'(rr_ptr_q) + k;
         if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
         scan_sel = PTR_W'(scan_idx);
         if (req_valid[scan_sel]) begin
            any_req   = 1'b1;
            grant_idx = scan_sel;
         end
      end
   end

   assign sel_a  = req_a[int'(grant_idx)*N +: N];
   assign sel_b  = req_b[int'(grant_idx)*N +: N];
   assign sel_op = req_op[int'(grant_idx)*3 +: 3];

   always_comb begin
      req_ready = '0;
      if (state_q == IDLE && any_req) req_ready[grant_idx] = 1'b1;
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = grant_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_ctrl_d  = alu_ctrl_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_flags_d = rsp_flags_q;
`ifdef ALU_OP_CHECK_EN
      op_err_d    = op_err_q;
      rsp_err_d   = rsp_err_q;
`endif
      case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_d = grant_idx;
               state_d = EXEC;
`ifdef ALU_OP_CHECK_EN
               op_err_d = sel_op[2];
               if (sel_op[2]) begin
                  // Unsupported op: keep the ALU parked; operands keep their old values.
                  alu_ctrl_d = 3'b000;
               end else begin
                  alu_a_d    = sel_a;
                  alu_b_d    = sel_b;
                  alu_ctrl_d = sel_op;
               end
`else
               alu_a_d    = sel_a;
               alu_b_d    = sel_b;
               alu_ctrl_d = sel_op;
`endif
            end
         end
         EXEC: begin
            rsp_data_d           = alu_out;
            rsp_flags_d          = alu_flags;
            rsp_valid_d          = '0;
            rsp_valid_d[grant_q] = 1'b1;
            rr_ptr_d = (grant_q == PTR_W'(NREQ - 1)) ? '0 : grant_q + 1'b1;
            state_d  = RESP;
`ifdef ALU_OP_CHECK_EN
            if (op_err_q) begin
               rsp_data_d  = '0;
               rsp_flags_d = '0;
               rsp_err_d   = 1'b1;
            end
`endif
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = '0;
               state_d     = IDLE;
`ifdef ALU_OP_CHECK_EN
               rsp_err_d   = 1'b0;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_ctrl_q  <= 3'b000;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rsp_flags_q <= '0;
`ifdef ALU_OP_CHECK_EN
         op_err_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_ctrl_q  <= alu_ctrl_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_flags_q <= rsp_flags_d;
`ifdef ALU_OP_CHECK_EN
         op_err_q    <= op_err_d;
         rsp_err_q   <= rsp_err_d;
`endif
      end
   end

   assign alu_A     = alu_a_q;
   assign alu_B     = alu_b_q;
   assign alu_ctrl  = alu_ctrl_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_flags = rsp_flags_q;
   assign busy      = (state_q != IDLE);
`ifdef ALU_OP_CHECK_EN
   assign rsp_err   = rsp_err_q;
`endif

endmodule

// File: tb/tb_scalar_alu_arbiter.sv
module tb_scalar_alu_arbiter;
   localparam int N    = 24;
   localparam int NREQ = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid, req_ready;
   logic [NREQ*N-1:0] req_a, req_b;
   logic [NREQ*3-1:0] req_op;
   logic [N-1:0]      alu_A, alu_B, alu_out;
   logic [2:0]        alu_ctrl;
   logic [4:0]        alu_flags;
   logic [NREQ-1:0]   rsp_valid;
   logic [N-1:0]      rsp_data;
   logic [4:0]        rsp_flags;
   logic              rsp_ready;
   logic              busy;
`ifdef ALU_OP_CHECK_EN
   logic              rsp_err;
`endif

   int checks = 0;
   int errors = 0;
   int m_ptr  = 0;

   bit          pv[NREQ];
   logic [N-1:0] pa[NREQ];
   logic [N-1:0] pb[NREQ];
   logic [2:0]   po[NREQ];

   scalar_alu_arbiter #(.N(N), .NREQ(NREQ)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .alu_A(alu_A), .alu_B(alu_B), .alu_ctrl(alu_ctrl),
      .alu_out(alu_out), .alu_flags(alu_flags),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
      .rsp_ready(rsp_ready), .busy(busy)
`ifdef ALU_OP_CHECK_EN
      , .rsp_err(rsp_err)
`endif
   );

   always #5 clk = ~clk;

   // Stand-in ALU: returns {flags, result}
   function automatic logic [N+4:0] ref_alu(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [2:0] op);
      logic [N:0]   wide;
      logic [N-1:0] r;
      logic         c, v;
      wide = '0; r = '0; c = 1'b0; v = 1'b0;
      case (op)
         3'd0: begin
            wide = {1'b0, a} + {1'b0, b}; r = wide[N-1:0]; c = wide[N];
            v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
         end
         3'd1: begin
            wide = {1'b0, a} - {1'b0, b}; r = wide[N-1:0]; c = wide[N];
            v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
         end
         3'd2: r = a << b[4:0];
         3'd3: r = a * b;
         default: r = a ^ b;
      endcase
      return {c, (r == '0), (a > b), v, r[N-1], r};
   endfunction

   always_comb {alu_flags, alu_out} = ref_alu(alu_A, alu_B, alu_ctrl);

   function automatic bit is_bad(input logic [2:0] op);
`ifdef ALU_OP_CHECK_EN
      return op[2];
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [N+4:0] exp_rsp(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [2:0] op);
      if (is_bad(op)) return '0;
      return ref_alu(a, b, op);
   endfunction

   function automatic int pick();
      for (int k = 0; k < NREQ; k++)
         if (pv[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
      return -1;
   endfunction

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]      = pv[i];
         req_a[i*N +: N]   = pa[i];
         req_b[i*N +: N]   = pb[i];
         req_op[i*3 +: 3]  = po[i];
      end
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < NREQ; i++) begin
         pv[i] = 1'b0; pa[i] = '0; pb[i] = '0; po[i] = '0;
      end
      drive();
   endtask

   task automatic test_reset();
      rst = 1'b1; rsp_ready = 1'b0; clear_reqs();
      repeat (3) @(negedge clk);
      checks++;
      if ({req_ready, alu_A, alu_B, alu_ctrl, rsp_valid, rsp_data, rsp_flags, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got ready=%b A=%0h B=%0h ctrl=%0d rv=%b rd=%0h rf=%b busy=%b exp all zero",
                  req_ready, alu_A, alu_B, alu_ctrl, rsp_valid, rsp_data, rsp_flags, busy);
      end
`ifdef ALU_OP_CHECK_EN
      checks++;
      if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", rsp_err); end
`endif
      rst = 1'b0; m_ptr = 0;
   endtask

   // Single-requester transactions, including latency and z flag
   task automatic test_single();
      int t_id[3]  = '{0, 1, 0};
      int t_a[3]   = '{130, 229, 5};
      int t_b[3]   = '{229, 130, 2};
      int t_op[3]  = '{0, 1, 2};
      int t_exp[3] = '{359, 99, 20};
      int g;
      for (int k = 0; k < 3; k++) begin
         g = t_id[k];
         pv[g] = 1'b1; pa[g] = N'(t_a[k]); pb[g] = N'(t_b[k]); po[g] = 3'(t_op[k]);
         drive(); #1;
         checks++;
         if (req_ready !== NREQ'(1 << g)) begin
            errors++; $display("FAIL single_ready[%0d] got %b exp %b", k, req_ready, NREQ'(1 << g));
         end
         @(posedge clk); #1; clear_reqs();
         @(negedge clk);
         checks++;
         if (rsp_valid !== '0 || busy !== 1'b1) begin
            errors++; $display("FAIL single_exec[%0d] got rv=%b busy=%b exp rv=0 busy=1", k, rsp_valid, busy);
         end
         @(negedge clk);
         checks++;
         if (rsp_valid !== NREQ'(1 << g) || rsp_data !== N'(t_exp[k]) || rsp_flags[3] !== (t_exp[k] == 0)) begin
            errors++;
            $display("FAIL single_rsp[%0d] got rv=%b d=%0d z=%b exp rv=%b d=%0d z=%b", k, rsp_valid,
                     rsp_data, rsp_flags[3], NREQ'(1 << g), t_exp[k], (t_exp[k] == 0));
         end
         rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
         checks++;
         if (busy !== 1'b0 || rsp_valid !== '0) begin
            errors++; $display("FAIL single_done[%0d] got busy=%b rv=%b exp 0 0", k, busy, rsp_valid);
         end
         m_ptr = (g + 1) % NREQ;
      end
   endtask

   task automatic test_back_to_back();
      int nrsp = 0;
      int exp_g;
      logic [N-1:0] exp_d;
      pv[0] = 1'b1; pa[0] = 24'd10; pb[0] = 24'd5; po[0] = 3'd3;
      pv[1] = 1'b1; pa[1] = 24'd1;  pb[1] = 24'd1; po[1] = 3'd0;
      drive(); rsp_ready = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid === 2'b11) begin errors++; $display("FAIL b2b_onehot got %b exp one-hot", rsp_valid); end
         if (rsp_valid !== '0) begin
            exp_g = m_ptr;
            exp_d = (exp_g == 0) ? 24'd50 : 24'd2;
            checks++;
            if (rsp_valid !== NREQ'(1 << exp_g) || rsp_data !== exp_d) begin
               errors++; $display("FAIL b2b_rsp got rv=%b d=%0d exp rv=%b d=%0d", rsp_valid, rsp_data,
                                  NREQ'(1 << exp_g), exp_d);
            end
            m_ptr = (exp_g + 1) % NREQ;
            nrsp++;
         end
      end
      clear_reqs(); rsp_ready = 1'b0;
      checks++;
      if (nrsp != 4) begin errors++; $display("FAIL b2b_throughput got %0d exp 4", nrsp); end
      @(negedge clk);
   endtask

   task automatic test_stall();
      pv[0] = 1'b1; pa[0] = 24'd7; pb[0] = 24'd3; po[0] = 3'd1;
      drive();
      @(posedge clk); #1;
      pv[0] = 1'b0; pv[1] = 1'b1; pa[1] = 24'd3; pb[1] = 24'd4; po[1] = 3'd0;
      drive();
      repeat (2) @(negedge clk);
      for (int c = 0; c < 6; c++) begin
         checks++;
         if (rsp_valid !== 2'b01 || rsp_data !== 24'd4 || rsp_flags !== 5'b00100 || req_ready !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold[%0d] got rv=%b d=%0d f=%b rdy=%b busy=%b exp 01 4 00100 00 1",
                     c, rsp_valid, rsp_data, rsp_flags, req_ready, busy);
         end
         @(negedge clk);
      end
      rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
      checks++;
      if (busy !== 1'b0 || rsp_valid !== '0) begin
         errors++; $display("FAIL stall_release got busy=%b rv=%b exp 0 0", busy, rsp_valid);
      end
      clear_reqs();
      m_ptr = 1;
   endtask

   task automatic test_reset_mid();
      pv[0] = 1'b1; pa[0] = 24'd77; pb[0] = 24'd1; po[0] = 3'd0;
      drive();
      @(posedge clk); #1; clear_reqs();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({req_ready, alu_A, alu_B, alu_ctrl, rsp_valid, rsp_data, rsp_flags, busy} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs got A=%0h ctrl=%0d rv=%b rd=%0h busy=%b exp all zero",
                  alu_A, alu_ctrl, rsp_valid, rsp_data, busy);
      end
      rst = 1'b0; m_ptr = 0;
      pv[0] = 1'b1; pv[1] = 1'b1; drive(); #1;
      checks++;
      if (req_ready !== 2'b01) begin errors++; $display("FAIL midreset_ptr got %b exp 01", req_ready); end
      clear_reqs();
      @(negedge clk);
      checks++;
      if (rsp_valid !== '0 || busy !== 1'b0) begin
         errors++; $display("FAIL midreset_norsp got rv=%b busy=%b exp 0 0", rsp_valid, busy);
      end
      pv[1] = 1'b1; pa[1] = 24'd229; pb[1] = 24'd130; po[1] = 3'd1; drive(); #1;
      checks++;
      if (req_ready !== 2'b10) begin errors++; $display("FAIL midreset_req1 got %b exp 10", req_ready); end
      @(posedge clk); #1; clear_reqs();
      repeat (2) @(negedge clk);
      checks++;
      if (rsp_valid !== 2'b10 || rsp_data !== 24'd99) begin
         errors++; $display("FAIL midreset_rsp got rv=%b d=%0d exp 10 99", rsp_valid, rsp_data);
      end
      rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
      m_ptr = 0;
   endtask

   task automatic test_bad_op();
      logic [N-1:0] prev_a, prev_b;
      prev_a = alu_A; prev_b = alu_B;
      pv[0] = 1'b1; pa[0] = 24'd9; pb[0] = 24'd4; po[0] = 3'b101; drive();
      @(posedge clk); #1; clear_reqs();
      @(negedge clk);
`ifdef ALU_OP_CHECK_EN
      checks++;
      if (alu_ctrl !== 3'b000 || alu_A !== prev_a || alu_B !== prev_b) begin
         errors++; $display("FAIL badop_alu got ctrl=%b A=%0d B=%0d exp 000 %0d %0d", alu_ctrl, alu_A, alu_B, prev_a, prev_b);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 2'b01 || rsp_data !== '0 || rsp_flags !== '0 || rsp_err !== 1'b1) begin
         errors++; $display("FAIL badop_rsp got rv=%b d=%0d f=%b err=%b exp 01 0 0 1", rsp_valid, rsp_data, rsp_flags, rsp_err);
      end
`else
      checks++;
      if (alu_ctrl !== 3'b101 || alu_A !== 24'd9 || alu_B !== 24'd4 || prev_a === 24'hxxxxxx) begin
         errors++; $display("FAIL badop_alu got ctrl=%b A=%0d B=%0d exp 101 9 4", alu_ctrl, alu_A, alu_B);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 2'b01 || rsp_data !== 24'd13) begin
         errors++; $display("FAIL badop_rsp got rv=%b d=%0d exp 01 13 (prev B %0d)", rsp_valid, rsp_data, prev_b);
      end
`endif
      rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== '0) begin errors++; $display("FAIL badop_clear got rv=%b exp 00", rsp_valid); end
`ifdef ALU_OP_CHECK_EN
      checks++;
      if (rsp_err !== 1'b0) begin errors++; $display("FAIL badop_errclr got %b exp 0", rsp_err); end
`endif
      m_ptr = 1;
   endtask

   // Random requests held until granted (or legally dropped), random response back-pressure
   task automatic test_random();
      int g, d;
      logic [N-1:0] a, b;
      logic [2:0]   op;
      logic [N+4:0] e;
      for (int it = 0; it < 60; it++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pv[i] && $urandom_range(0, 2) != 0) begin
               pv[i] = 1'b1; pa[i] = N'($urandom); pb[i] = N'($urandom); po[i] = 3'($urandom_range(0, 7));
            end else if (pv[i] && $urandom_range(0, 9) == 0) begin
               pv[i] = 1'b0;
            end
         end
         drive(); #1;
         g = pick();
         if (g < 0) begin
            checks++;
            if (req_ready !== '0 || busy !== 1'b0) begin
               errors++; $display("FAIL rand_idle got rdy=%b busy=%b exp 0 0", req_ready, busy);
            end
            @(negedge clk);
            continue;
         end
         checks++;
         if (req_ready !== NREQ'(1 << g)) begin
            errors++; $display("FAIL rand_grant got %b exp %b", req_ready, NREQ'(1 << g));
         end
         a = pa[g]; b = pb[g]; op = po[g]; e = exp_rsp(a, b, op);
         @(posedge clk); #1;
         pv[g] = 1'b0; drive();
         @(negedge clk);
         checks++;
         if (alu_ctrl !== (is_bad(op) ? 3'b000 : op) || (!is_bad(op) && (alu_A !== a || alu_B !== b))) begin
            errors++; $display("FAIL rand_alu got ctrl=%b A=%0h B=%0h exp ctrl=%b A=%0h B=%0h", alu_ctrl, alu_A, alu_B, op, a, b);
         end
         @(negedge clk);
         d = $urandom_range(0, 3);
         for (int c = 0; c <= d; c++) begin
            checks++;
            if (rsp_valid !== NREQ'(1 << g) || {rsp_flags, rsp_data} !== e || req_ready !== '0) begin
               errors++; $display("FAIL rand_rsp got rv=%b f=%b d=%0h rdy=%b exp rv=%b f=%b d=%0h", rsp_valid,
                                  rsp_flags, rsp_data, req_ready, NREQ'(1 << g), e[N+4:N], e[N-1:0]);
            end
            if (c == d) rsp_ready = 1'b1;
            @(negedge clk);
         end
         rsp_ready = 1'b0;
         checks++;
         if (rsp_valid !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL rand_done got rv=%b busy=%b exp 0 0", rsp_valid, busy);
         end
         m_ptr = (g + 1) % NREQ;
      end
      clear_reqs();
   endtask

   initial begin
      rst = 1'b1; rsp_ready = 1'b0; clear_reqs();
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      test_bad_op();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end
endmodule
